// File: rtl/drv_fanout_pkg.sv
// Shared types and constants for the fan-out driver stage: FSM state codes,
// transfer counter width and a small bit-count helper.
package drv_fanout_pkg;

  localparam int XFER_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BCAST = 2'd1;
  localparam state_t LAST  = 2'd2;

  // Branch masks are at most 8 wide, so callers zero-extend into this argument.
  function automatic int unsigned count_ones(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/drv_skid_fifo.sv
// Two-entry shift FIFO feeding the fan-out stage. Exposes the post-edge head
// so the branch registers can load in the same edge as the FIFO write.
module drv_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  output logic             in_ready,
  output logic             head_valid,
  output logic             next_valid,
  output logic [WIDTH-1:0] next_data
);

  logic [1:0]       count, count_n, wr_idx;
  logic [WIDTH-1:0] entry0, entry1, entry0_n, entry1_n;
  logic             push;

  assign push = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    entry0_n = entry0;
    entry1_n = entry1;
    count_n  = count + {1'b0, push} - {1'b0, pop};
    wr_idx   = count - {1'b0, pop};
    if (pop) entry0_n = entry1;
    if (push) begin
      if (wr_idx == 2'd0) entry0_n = in_data;
      else                entry1_n = in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_n;
      in_ready <= (count_n != 2'd2);
    end
  end

  // NOTE: storage entries are not reset; occupancy alone decides whether they are meaningful.
  always_ff @(posedge clk) begin
    entry0 <= entry0_n;
    entry1 <= entry1_n;
  end

  assign head_valid = (count != 2'd0);
  assign next_valid = (count_n != 2'd0);
  assign next_data  = entry0_n;

endmodule

// File: rtl/drv_fanout_stage.sv
// Broadcasts each buffered word to NUM_LOADS independent branches, retiring
// the word once every branch has handshaken it.
module drv_fanout_stage
  import drv_fanout_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       tie_en,
  output logic [NUM_LOADS-1:0]       load_valid,
  input  logic [NUM_LOADS-1:0]       load_ready,
  output logic [NUM_LOADS*WIDTH-1:0] load_data,
  output logic [WIDTH-1:0]           load_output,
  output logic [XFER_CNT_W-1:0]      xfer_count
);

  logic                 head_valid, next_valid, pop;
  logic [WIDTH-1:0]     next_data, branch_word;
  logic [NUM_LOADS-1:0] done, done_n, fire, pending_n;
  state_t               state, state_n;

  drv_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .pop        (pop),
    .in_ready   (in_ready),
    .head_valid (head_valid),
    .next_valid (next_valid),
    .next_data  (next_data)
  );

  assign load_valid = {NUM_LOADS{head_valid}} & ~done;
  assign fire       = load_valid & load_ready;
  assign pop        = head_valid && ((done | fire) == {NUM_LOADS{1'b1}});

  always_comb begin
    done_n    = pop ? '0 : (done | fire);
    pending_n = ~done_n;
    if (!next_valid)                         state_n = IDLE;
    else if (count_ones(8'(pending_n)) == 1) state_n = LAST;
    else                                     state_n = BCAST;
  end

  // Tie mode only masks what the branches see; the FIFO keeps the real words.
  assign branch_word = (tie_en || !next_valid) ? '0 : next_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= '0;
      state       <= IDLE;
      xfer_count  <= '0;
      load_output <= '0;
    end else begin
      done        <= done_n;
      state       <= state_n;
      load_output <= branch_word;
      if (pop) xfer_count <= xfer_count + XFER_CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_branch
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= branch_word;
    end

    assign load_data[i*WIDTH +: WIDTH] = data_q;
  end

endmodule

// File: tb/tb_drv_fanout_stage.sv
// Directed bench for drv_fanout_stage: reset, broadcast, staggered accept,
// backpressure, tie mode, counter wrap and asynchronous reset mid-broadcast.
module tb_drv_fanout_stage;
  import drv_fanout_pkg::*;

  localparam int WIDTH = 8;
  localparam int NL    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  tie_en;
  logic [NL-1:0]         load_valid;
  logic [NL-1:0]         load_ready;
  logic [NL*WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]      load_output;
  logic [XFER_CNT_W-1:0] xfer_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  drv_fanout_stage #(.WIDTH(WIDTH), .NUM_LOADS(NL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tie_en      (tie_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_output (load_output),
    .xfer_count  (xfer_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    tie_en     = 1'b0;
    load_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tie_en = 1'b0; load_ready = '0;
    #2;
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL rst_valid got %b want 000", load_valid); end
    n_vec++; if (load_data !== 24'h0) begin n_err++; $display("FAIL rst_data got %h want 000000", load_data); end
    n_vec++; if (load_output !== 8'h00) begin n_err++; $display("FAIL rst_output got %h want 00", load_output); end
    n_vec++; if (xfer_count !== 16'h0) begin n_err++; $display("FAIL rst_count got %h want 0000", xfer_count); end
    n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL rst_state got %0d want %0d", dut.state, IDLE); end
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    load_ready = 3'b111; in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    n_vec++; if (load_valid !== 3'b111) begin n_err++; $display("FAIL basic_valid got %b want 111", load_valid); end
    n_vec++; if (load_data !== {3{8'hA5}}) begin n_err++; $display("FAIL basic_data got %h want a5a5a5", load_data); end
    n_vec++; if (load_output !== 8'hA5) begin n_err++; $display("FAIL basic_output got %h want a5", load_output); end
    n_vec++; if (dut.state !== BCAST) begin n_err++; $display("FAIL basic_state_bcast got %0d want %0d", dut.state, BCAST); end
    step();
    n_vec++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", xfer_count); end
    n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL basic_state_idle got %0d want %0d", dut.state, IDLE); end
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL basic_valid_after got %b want 000", load_valid); end
  endtask

  task automatic test_stagger();
    do_reset();
    load_ready = 3'b000; in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    n_vec++; if (load_valid !== 3'b111) begin n_err++; $display("FAIL stag_valid0 got %b want 111", load_valid); end
    load_ready = 3'b001;
    step();
    n_vec++; if (load_valid !== 3'b110) begin n_err++; $display("FAIL stag_valid1 got %b want 110", load_valid); end
    n_vec++; if (dut.state !== BCAST) begin n_err++; $display("FAIL stag_state1 got %0d want %0d", dut.state, BCAST); end
    load_ready = 3'b010;
    step();
    n_vec++; if (load_valid !== 3'b100) begin n_err++; $display("FAIL stag_valid2 got %b want 100", load_valid); end
    n_vec++; if (dut.state !== LAST) begin n_err++; $display("FAIL stag_state2 got %0d want %0d", dut.state, LAST); end
    n_vec++; if (load_data !== {3{8'h3C}}) begin n_err++; $display("FAIL stag_hold got %h want 3c3c3c", load_data); end
    n_vec++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL stag_count_early got %0d want 0", xfer_count); end
    load_ready = 3'b100;
    step();
    n_vec++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL stag_count got %0d want 1", xfer_count); end
    n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL stag_state3 got %0d want %0d", dut.state, IDLE); end
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL stag_valid3 got %b want 000", load_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_ready = 3'b000; in_valid = 1'b1; in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_data = 8'h33;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", in_ready); end
    step();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    n_vec++; if (load_data !== {3{8'h11}}) begin n_err++; $display("FAIL bp_head got %h want 111111", load_data); end
    load_ready = 3'b111;
    step();
    n_vec++; if (load_data !== {3{8'h22}}) begin n_err++; $display("FAIL bp_second got %h want 222222", load_data); end
    n_vec++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL bp_count1 got %0d want 1", xfer_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_vec++; if (load_data !== {3{8'h33}}) begin n_err++; $display("FAIL bp_third got %h want 333333", load_data); end
    step();
    n_vec++; if (xfer_count !== 16'd3) begin n_err++; $display("FAIL bp_count3 got %0d want 3", xfer_count); end
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL bp_drained got %b want 000", load_valid); end
  endtask

  task automatic test_tie();
    do_reset();
    tie_en = 1'b1; load_ready = 3'b111; in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    n_vec++; if (load_data !== 24'h0) begin n_err++; $display("FAIL tie_data got %h want 000000", load_data); end
    n_vec++; if (load_output !== 8'h00) begin n_err++; $display("FAIL tie_output got %h want 00", load_output); end
    n_vec++; if (load_valid !== 3'b111) begin n_err++; $display("FAIL tie_valid got %b want 111", load_valid); end
    step();
    n_vec++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL tie_count got %0d want 1", xfer_count); end
    tie_en = 1'b0; in_valid = 1'b1; in_data = 8'h0F;
    step();
    in_valid = 1'b0;
    n_vec++; if (load_data !== {3{8'h0F}}) begin n_err++; $display("FAIL untie_data got %h want 0f0f0f", load_data); end
    n_vec++; if (load_output !== 8'h0F) begin n_err++; $display("FAIL untie_output got %h want 0f", load_output); end
    step();
    // A word buffered under tie mode reappears intact once tie mode is released.
    tie_en = 1'b1; load_ready = 3'b000; in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    n_vec++; if (load_data !== 24'h0) begin n_err++; $display("FAIL tie_hold_data got %h want 000000", load_data); end
    tie_en = 1'b0;
    step();
    n_vec++; if (load_data !== {3{8'hAA}}) begin n_err++; $display("FAIL tie_preserved got %h want aaaaaa", load_data); end
    n_vec++; if (xfer_count !== 16'd2) begin n_err++; $display("FAIL tie_count2 got %0d want 2", xfer_count); end
  endtask

  task automatic test_wrap_and_reset();
    int cycles;
    do_reset();
    load_ready = 3'b111; in_valid = 1'b1; in_data = 8'h01;
    cycles = 0;
    while (xfer_count != 16'hFFFE && cycles < 70000) begin
      step();
      cycles++;
    end
    n_vec++; if (xfer_count !== 16'hFFFE) begin n_err++; $display("FAIL wrap_preload got %h want fffe (timeout)", xfer_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wrap_stream_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    step();
    n_vec++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got %h want ffff", xfer_count); end
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    step();
    n_vec++; if (xfer_count !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", xfer_count); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    load_ready = 3'b000; in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    n_vec++; if (xfer_count !== 16'd1) begin n_err++; $display("FAIL pre_rst_count got %0d want 1", xfer_count); end
    n_vec++; if (dut.state !== BCAST) begin n_err++; $display("FAIL pre_rst_state got %0d want %0d", dut.state, BCAST); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL arst_valid got %b want 000", load_valid); end
    n_vec++; if (xfer_count !== 16'h0) begin n_err++; $display("FAIL arst_count got %h want 0000", xfer_count); end
    n_vec++; if (load_data !== 24'h0) begin n_err++; $display("FAIL arst_data got %h want 000000", load_data); end
    do_reset();
    n_vec++; if (load_valid !== 3'b000) begin n_err++; $display("FAIL arst_discard got %b want 000", load_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stagger();
    test_backpressure();
    test_tie();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
